// File: rtl/fp16_pkg.sv
// Shared FP16 datapath definitions: field widths, special encodings and
// the result class carried from normalization into round/pack.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int PROD_W  = 2 * (MAN_W + 1);
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        ZERO,
        UFLOW,
        INF,
        NORMAL
    } fp_class_e;

    // Normalized, not-yet-rounded operand held between the two stages.
    typedef struct packed {
        logic             sign;
        fp_class_e        cls;
        logic [EXP_W:0]   e;
        logic [MAN_W-1:0] frac;
        logic             guard;
        logic             sticky;
    } s1_t;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on a normalized fraction; a carry out of the
// fraction renormalizes by bumping the exponent.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [MAN_W-1:0] frac_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic [EXP_W:0]   e_i,
    output logic [MAN_W-1:0] frac_o,
    output logic [EXP_W:0]   e_o,
    output logic             carry_o
);

    logic           rnd;
    logic [MAN_W:0] sum;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        rnd     = guard_i && (sticky_i || frac_i[0]);
        sum     = {1'b0, frac_i} + {{MAN_W{1'b0}}, rnd};
        carry_o = sum[MAN_W];
        frac_o  = carry_o ? '0 : sum[MAN_W-1:0];
        e_o     = e_i + {{EXP_W{1'b0}}, carry_o};
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// Two-stage FP16 normalize / round / pack with valid-ready on both sides.
// Stage 1 aligns the 22-bit product; stage 2 rounds RNE and packs flags.
module fp16_normalize_round
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [4:0]  in_exp,
    input  logic [21:0] in_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    logic adv1, adv2;
    logic v1_q, v1_d, v2_q, v2_d;
    s1_t  s1_q, s1_d;

    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d, ufl_q, ufl_d, inx_q, inx_d;

    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W:0]   rnd_e;
    logic             rnd_carry;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        if (adv1) v1_d = in_valid;
        if (adv1 && in_valid) begin
            s1_d.sign = in_sign;
            if (in_prod[PROD_W-1]) begin
                s1_d.frac   = in_prod[20:11];
                s1_d.guard  = in_prod[10];
                s1_d.sticky = |in_prod[9:0];
                s1_d.e      = {1'b0, in_exp} + 6'd1;
            end else begin
                s1_d.frac   = in_prod[19:10];
                s1_d.guard  = in_prod[9];
                s1_d.sticky = |in_prod[8:0];
                s1_d.e      = {1'b0, in_exp};
            end
            if (in_prod == '0)                   s1_d.cls = ZERO;
            else if (in_exp == 5'(EXP_MAX))      s1_d.cls = INF;
            else if (in_exp == '0)               s1_d.cls = UFLOW;
            else                                 s1_d.cls = NORMAL;
        end
    end

    fp16_round_rne u_round (
        .frac_i   (s1_q.frac),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .e_i      (s1_q.e),
        .frac_o   (rnd_frac),
        .e_o      (rnd_e),
        .carry_o  (rnd_carry)
    );

    always_comb begin
        v2_d     = v2_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ufl_d    = ufl_q;
        inx_d    = inx_q;
        if (adv2) v2_d = v1_q;
        if (adv2 && v1_q) begin
            ovf_d = 1'b0;
            ufl_d = 1'b0;
            inx_d = 1'b0;
            unique case (s1_q.cls)
                ZERO: result_d = {s1_q.sign, 15'h0};
                UFLOW: begin
                    result_d = {s1_q.sign, 15'h0};
                    ufl_d    = 1'b1;
                    inx_d    = 1'b1;
                end
                INF: begin
                    result_d = FP16_POS_INF | {s1_q.sign, 15'h0};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end
                default: begin
                    // rnd_carry is already folded into rnd_e.
                    if (rnd_e >= 6'(EXP_MAX)) begin
                        result_d = FP16_POS_INF | {s1_q.sign, 15'h0};
                        ovf_d    = 1'b1;
                        inx_d    = 1'b1;
                    end else begin
                        result_d = {s1_q.sign, rnd_e[EXP_W-1:0], rnd_frac};
                        inx_d    = s1_q.guard | s1_q.sticky;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ufl_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ufl_q    <= ufl_d;
            inx_q    <= inx_d;
        end
    end

    // NOTE: the stage-1 payload is qualified by v1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    assign out_valid     = v2_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = ufl_q;
    assign out_inexact   = inx_q;

    logic unused_carry;
    assign unused_carry = rnd_carry;

endmodule

// File: doc/fp16_normalize_round.md
Name: fp16_normalize_round

Overview:
- Downstream neighbour of the FP16 exponent adder in the MAC datapath.
- Consumes the sign, the biased/saturated exponent and the 22-bit significand product.
- Normalizes the product, rounds it to nearest-even and packs an IEEE-754 half-precision result with status flags.
- Two-stage pipeline with valid/ready handshake on both sides, so the multiply path can be stalled by the accumulator.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width; the product width is 2*(MAN_W+1) = 22.
- EXP_MAX, 31, all-ones exponent (Inf/NaN code).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept this cycle.
- in_sign  in  1  product sign (sign_a XOR sign_b).
- in_exp  in  5  biased exponent from the adder; 0 means underflow, 31 means overflow.
- in_prod  in  22  unsigned product of two 11-bit significands (hidden bits included).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  16  packed FP16 {sign, exp[4:0], frac[9:0]}.
- out_overflow  out  1  result saturated to Inf.
- out_underflow  out  1  result flushed to zero.
- out_inexact  out  1  a nonzero guard or sticky bit was discarded.

Behaviour:
- Reset (async, active-high) clears both stage valid bits. While rst is high, out_valid=0, out_result=0 and all flags=0. A reset mid-operation drops in-flight data; no output appears after reset until a new input is accepted.
- Handshake:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1.
  - A transfer occurs when valid && ready.
  - out_result and flags hold stable while out_valid && !out_ready.
  - Order is preserved and there is no drop or duplication.
  - Full throughput is 1 result/cycle. Latency is 2 cycles from input acceptance to out_valid (no stall).
- Stage 1 (normalize), registered into s1:
  - If in_prod[21]=1: frac=in_prod[20:11], guard=in_prod[10], sticky=|in_prod[9:0], e=in_exp+1 (6-bit).
  - Otherwise: frac=in_prod[19:10], guard=in_prod[9], sticky=|in_prod[8:0], e=in_exp.
  - Class is captured with this precedence:
    - zero if in_prod==0;
    - else inf if in_exp==31;
    - else uflow if in_exp==0;
    - else normal.
- Stage 2 (round/pack), registered into output:
  - rnd = guard && (sticky || frac[0]).
  - Compute frac+rnd in 11 bits. On carry out: frac=0 and e=e+1.
  - Class zero: out_result={sign,15'h0}; no flags set.
  - Class uflow: out_result={sign,15'h0}; out_underflow=1; out_inexact=1.
  - Class inf, or normal with e>=31 after rounding: out_result={sign,5'h1F,10'h0}; out_overflow=1; out_inexact=1.
  - Normal otherwise: out_result={sign,e[4:0],frac}; out_inexact=guard|sticky.
- No NaN generation and no subnormal output; NaN operands are handled upstream.
- Exponent arithmetic uses 6 bits so that the +1 from normalization and rounding cannot wrap.

Decomposition:
- Shared package fp16_pkg: EXP_W, MAN_W, BIAS=15, EXP_MAX, FP16_POS_INF=16'h7C00, and the result-class enum {ZERO, UFLOW, INF, NORMAL}.
- One natural sub-module: fp16_round_rne, a combinational block taking {frac, guard, sticky, e} and returning the rounded {frac, e, carry}. It is instanced in stage 2.

Test Plan:
- sign=0, exp=15, prod=22'h100000 -> after 2 cycles out_result=16'h3C00; all flags 0.
- sign=0, exp=15, prod=22'h240000 (1.5*1.5) -> out_result=16'h4080 (2.25), exact.
- sign=0, exp=15, prod=22'h1FFFFF -> round carry, out_result=16'h4000, out_inexact=1. The same product with exp=30 -> 16'h7C00 with out_overflow=1.
- sign=1, exp=0, prod=22'h100000 -> 16'h8000 with out_underflow=1. Then prod=0, exp=20 -> 16'h0000 with all flags 0.
- Tie case: exp=15, prod=22'h100200 (guard=1, sticky=0, lsb=0) -> 16'h3C00. prod=22'h100600 (lsb=1) -> 16'h3C02.
- Backpressure and reset:
  - Stream 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted; out_result is held stable.
  - Release out_ready -> the 4 results emerge in order with no gaps.
  - Assert rst with 2 items in flight -> out_valid=0 immediately, and nothing is emitted after release.
